gorev4_histogram_reader: RTL

Receiving end of the gorev4 histogram output stream. Captures the 256 `{index[7:0], count[23:0]}` words the histogram table emits on its 32-bit data output while its send flag is high, tolerating words held for several cycles. Then builds a cumulative (CDF) table and checks the pixel total against the frame size. Results go to a registered random-access read port for the equalization / reporting logic downstream.

---
 rtl/gorev4_histogram_reader_if.sv | 9 +
 rtl/gorev4_histogram_reader.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/gorev4_histogram_reader_if.sv
// Word stream from the gorev4 histogram table to its reader.
interface gorev4_histogram_reader_if;
    logic        veri_gonder;
    logic [31:0] veri;
    logic        veri_al;

    modport master (output veri_gonder, output veri, input veri_al);
    modport slave  (input veri_gonder, input veri, output veri_al);
endinterface

// File: rtl/gorev4_histogram_reader.sv
// Captures the 256 histogram bins, builds a saturating CDF table and checks the
// pixel total; results are served through a registered random-access read port.
module gorev4_histogram_reader #(
    parameter int PIXEL_COUNT = 76800,
    parameter int TIMEOUT     = 1024
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            en_i,
    gorev4_histogram_reader_if.slave        hist_if,
    input  logic [7:0]                      rd_addr_i,
    output logic [23:0]                     rd_count_o,
    output logic [23:0]                     rd_cdf_o,
    output logic [31:0]                     total_o,
    output logic                            done_o,
    output logic                            hata_o,
    output logic [1:0]                      err_code_o
);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {S_IDLE, S_COLLECT, S_CDF, S_CHECK, S_DONE, S_ERR} state_e;

    localparam logic [1:0] E_ORDER   = 2'd1;
    localparam logic [1:0] E_TIMEOUT = 2'd2;
    localparam logic [1:0] E_SUM     = 2'd3;

    state_e        state_q, state_d;
    logic [7:0]    exp_q, exp_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [31:0]   total_q, total_d;
    logic [7:0]    j_q, j_d;
    logic [23:0]   acc_q, acc_d;
    logic [1:0]    err_q, err_d;
    logic [23:0]   rd_count_q, rd_cdf_q;
    logic [23:0]   cnt_mem [256];
    logic [23:0]   cdf_mem [256];

    logic [7:0]    idx;
    logic [23:0]   cnt_in;
    logic          accept, hold_rep, cnt_we, cdf_we;
    logic [TW-1:0] timer_inc;
    logic [24:0]   cdf_sum;

    assign idx       = hist_if.veri[31:24];
    assign cnt_in    = hist_if.veri[23:0];
    assign accept    = hist_if.veri_gonder && (idx == exp_q);
    // A producer holding the last word for extra cycles shows index exp-1.
    assign hold_rep  = hist_if.veri_gonder && (exp_q != 8'd0) && (idx == exp_q - 8'd1);
    assign timer_inc = timer_q + TW'(1);
    assign cdf_sum   = {1'b0, acc_q} + {1'b0, cnt_mem[j_q]};

    always_comb begin
        state_d = state_q;
        exp_d   = exp_q;
        timer_d = timer_q;
        total_d = total_q;
        j_d     = j_q;
        acc_d   = acc_q;
        err_d   = err_q;
        cnt_we  = 1'b0;
        cdf_we  = 1'b0;
        if (en_i) begin
            unique case (state_q)
                S_IDLE: state_d = S_COLLECT;
                S_COLLECT: begin
                    if (accept) begin
                        cnt_we  = 1'b1;
                        total_d = total_q + {8'd0, cnt_in};
                        exp_d   = exp_q + 8'd1;
                        timer_d = '0;
                        if (exp_q == 8'hFF) begin
                            state_d = S_CDF;
                            j_d     = 8'd0;
                            acc_d   = 24'd0;
                        end
                    end else if (hist_if.veri_gonder && !hold_rep) begin
                        state_d = S_ERR;
                        err_d   = E_ORDER;
                    end else begin
                        timer_d = timer_inc;
                        if (timer_inc == TW'(TIMEOUT)) begin
                            state_d = S_ERR;
                            err_d   = E_TIMEOUT;
                        end
                    end
                end
                S_CDF: begin
                    cdf_we = 1'b1;
                    acc_d  = cdf_sum[24] ? 24'hFFFFFF : cdf_sum[23:0];
                    j_d    = j_q + 8'd1;
                    if (j_q == 8'hFF) state_d = S_CHECK;
                end
                S_CHECK: begin
                    if (total_q == 32'(PIXEL_COUNT)) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_ERR;
                        err_d   = E_SUM;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q    <= S_IDLE;
            exp_q      <= 8'd0;
            timer_q    <= '0;
            total_q    <= 32'd0;
            j_q        <= 8'd0;
            acc_q      <= 24'd0;
            err_q      <= 2'd0;
            rd_count_q <= 24'd0;
            rd_cdf_q   <= 24'd0;
        end else begin
            state_q    <= state_d;
            exp_q      <= exp_d;
            timer_q    <= timer_d;
            total_q    <= total_d;
            j_q        <= j_d;
            acc_q      <= acc_d;
            err_q      <= err_d;
            rd_count_q <= cnt_mem[rd_addr_i];
            rd_cdf_q   <= cdf_mem[rd_addr_i];
        end
    end

    // Tables keep their contents across reset.
    always_ff @(posedge clk_i) begin
        if (rst_i && cnt_we) cnt_mem[exp_q] <= cnt_in;
        if (rst_i && cdf_we) cdf_mem[j_q]   <= acc_d;
    end

    assign hist_if.veri_al = (state_q == S_COLLECT);
    assign done_o          = (state_q == S_DONE);
    assign hata_o          = (state_q == S_ERR);
    assign err_code_o      = err_q;
    assign total_o         = total_q;
    assign rd_count_o      = rd_count_q;
    assign rd_cdf_o        = rd_cdf_q;
endmodule
